// File: rtl/key_debouncer_if.sv
// Key pin / debounced-output bundle shared by key_debouncer and its consumers.
// master drives the raw pins and receives the conditioned outputs; slave is the debouncer side.
interface key_debouncer_if #(
   parameter int KEYS = 3
);
   logic [KEYS-1:0] key_raw;
   logic [KEYS-1:0] key_state;
   logic [KEYS-1:0] key_press;
   logic [KEYS-1:0] key_release;

   modport master (
      output key_raw,
      input  key_state,
      input  key_press,
      input  key_release
   );

   modport slave (
      input  key_raw,
      output key_state,
      output key_press,
      output key_release
   );
endinterface

// File: rtl/key_debouncer.sv
// Per-key 2-flop synchronizer, debounce FSM and registered press/release strobes.
// Define KEY_REPEAT_EN to add hold-to-repeat press strobes.
//
// state      | meaning
// -----------+----------------------------------------------
// ST_UP      | key released and accepted as released
// ST_PEND_DN | pressed level seen, waiting for it to be stable
// ST_DOWN    | key accepted as pressed
// ST_PEND_UP | released level seen, waiting for it to be stable
module key_debouncer #(
   parameter int KEYS            = 3,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int PRESSED_LEVEL   = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 6250000
) (
   input  logic             clk,
   input  logic             rst,
   key_debouncer_if.slave   kif
);
   localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic          PRESS_LVL = (PRESSED_LEVEL != 0);
   localparam logic          REL_LVL   = ~PRESS_LVL;

   if (KEYS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
       (PRESSED_LEVEL != 0 && PRESSED_LEVEL != 1)) begin : g_bad_param
      $error("key_debouncer: illegal parameter value");
   end

`ifdef KEY_REPEAT_EN
   localparam int            HOLD_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int            HW         = $clog2(HOLD_MAX + 1);
   localparam logic [HW-1:0] HOLD_FIRST = HW'(REPEAT_DELAY - 1);
   localparam logic [HW-1:0] HOLD_NEXT  = HW'(REPEAT_PERIOD - 1);
`endif

   typedef enum logic [1:0] {ST_UP, ST_PEND_DN, ST_DOWN, ST_PEND_UP} key_fsm_e;

   logic [KEYS-1:0] sync1_q, sync2_q;
   logic [KEYS-1:0] state_w, press_w, release_w;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= {KEYS{REL_LVL}};
         sync2_q <= {KEYS{REL_LVL}};
      end else begin
         sync1_q <= kif.key_raw;
         sync2_q <= sync1_q;
      end
   end

   for (genvar i = 0; i < KEYS; i++) begin : g_key
      key_fsm_e      fsm_q, fsm_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          lvl_q, lvl_d;
      logic          press_q, press_d;
      logic          rel_q, rel_d;
      logic          p;
`ifdef KEY_REPEAT_EN
      logic [HW-1:0] hold_q, hold_d;
      logic          rpt_q, rpt_d;
`endif

      assign p = (sync2_q[i] == PRESS_LVL);

      always_ff @(posedge clk) begin
         if (rst) begin
            fsm_q   <= ST_UP;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
            hold_q  <= '0;
            rpt_q   <= 1'b0;
`endif
         end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
            rel_q   <= rel_d;
`ifdef KEY_REPEAT_EN
            hold_q  <= hold_d;
            rpt_q   <= rpt_d;
`endif
         end
      end

      always_comb begin
         fsm_d   = fsm_q;
         cnt_d   = cnt_q;
         lvl_d   = lvl_q;
         press_d = 1'b0;
         rel_d   = 1'b0;
`ifdef KEY_REPEAT_EN
         hold_d  = hold_q;
         rpt_d   = rpt_q;
`endif
         unique case (fsm_q)
            ST_UP: begin
               if (p) begin
                  fsm_d = ST_PEND_DN;
                  cnt_d = '0;
               end
            end
            ST_PEND_DN: begin
               if (!p) begin
                  fsm_d = ST_UP;
                  cnt_d = '0;
               end else if (cnt_q == CNT_LAST) begin
                  fsm_d   = ST_DOWN;
                  cnt_d   = '0;
                  lvl_d   = 1'b1;
                  press_d = 1'b1;
`ifdef KEY_REPEAT_EN
                  hold_d  = '0;
                  rpt_d   = 1'b0;
`endif
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_DOWN: begin
               if (!p) begin
                  fsm_d = ST_PEND_UP;
                  cnt_d = '0;
               end
`ifdef KEY_REPEAT_EN
               // first repeat after REPEAT_DELAY, then every REPEAT_PERIOD
               else if (!rpt_q) begin
                  if (hold_q == HOLD_FIRST) begin
                     press_d = 1'b1;
                     hold_d  = '0;
                     rpt_d   = 1'b1;
                  end else begin
                     hold_d = hold_q + HW'(1);
                  end
               end else if (hold_q == HOLD_NEXT) begin
                  press_d = 1'b1;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
`endif
            end
            ST_PEND_UP: begin
               if (p) begin
                  fsm_d = ST_DOWN;
                  cnt_d = '0;
               end else if (cnt_q == CNT_LAST) begin
                  fsm_d = ST_UP;
                  cnt_d = '0;
                  lvl_d = 1'b0;
                  rel_d = 1'b1;
`ifdef KEY_REPEAT_EN
                  hold_d = '0;
                  rpt_d  = 1'b0;
`endif
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               fsm_d = ST_UP;
               cnt_d = '0;
            end
         endcase
      end

      assign state_w[i]   = lvl_q;
      assign press_w[i]   = press_q;
      assign release_w[i] = rel_q;
   end

   assign kif.key_state   = state_w;
   assign kif.key_press   = press_w;
   assign kif.key_release = release_w;
endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer: KEYS=3, DEBOUNCE_CYCLES=4, active-high keys.
// Define KEY_REPEAT_EN to also exercise auto-repeat (REPEAT_DELAY=10, REPEAT_PERIOD=5).
module tb_key_debouncer;
   localparam int KEYS = 3;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   key_debouncer_if #(.KEYS(KEYS)) kif ();

   key_debouncer #(
      .KEYS            (KEYS),
      .DEBOUNCE_CYCLES (4),
      .PRESSED_LEVEL   (1),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kif (kif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input int e, input logic [2:0] st,
                             input logic [2:0] pr, input logic [2:0] rl);
      check($sformatf("%s[%0d] state", tag, e),   32'(kif.key_state),   32'(st));
      check($sformatf("%s[%0d] press", tag, e),   32'(kif.key_press),   32'(pr));
      check($sformatf("%s[%0d] release", tag, e), 32'(kif.key_release), 32'(rl));
   endtask

   initial begin
      rst         = 1'b1;
      kif.key_raw = '0;
      tick();
      tick();
      rst = 1'b0;
      check_outs("reset", 0, 3'b000, 3'b000, 3'b000);

      // key 1 bounces: 3 high samples never reach the 4-cycle debounce
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 6; c++) begin
            kif.key_raw = (c < 3) ? 3'b010 : 3'b000;
            tick();
            check_outs("glitch1", r * 6 + c, 3'b000, 3'b000, 3'b000);
         end
      end
      tick();
      tick();

      kif.key_raw = 3'b001;
      for (int e = 0; e <= 8; e++) begin
         tick();
         check_outs("press0", e, (e >= 6) ? 3'b001 : 3'b000, (e == 6) ? 3'b001 : 3'b000, 3'b000);
      end

      kif.key_raw = 3'b000;
      for (int e = 0; e <= 8; e++) begin
         tick();
         check_outs("release0", e, (e >= 6) ? 3'b000 : 3'b001, 3'b000, (e == 6) ? 3'b001 : 3'b000);
      end

      kif.key_raw = 3'b101;
      for (int e = 0; e <= 8; e++) begin
         tick();
         check_outs("press02", e, (e >= 6) ? 3'b101 : 3'b000, (e == 6) ? 3'b101 : 3'b000, 3'b000);
      end

      kif.key_raw = 3'b000;
      for (int e = 0; e <= 8; e++) begin
         tick();
         check_outs("release02", e, (e >= 6) ? 3'b000 : 3'b101, 3'b000, (e == 6) ? 3'b101 : 3'b000);
      end

      // key 2 reaches PEND_DN with cnt=2, then a one-cycle reset
      kif.key_raw = 3'b100;
      for (int e = 0; e <= 4; e++) begin
         tick();
         check_outs("pend2", e, 3'b000, 3'b000, 3'b000);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_outs("rst_mid", 0, 3'b000, 3'b000, 3'b000);
      for (int e = 0; e <= 8; e++) begin
         tick();
         check_outs("repress2", e, (e >= 6) ? 3'b100 : 3'b000, (e == 6) ? 3'b100 : 3'b000, 3'b000);
      end

      // reset while key 2 is DOWN must not produce a release strobe
      rst         = 1'b1;
      kif.key_raw = 3'b000;
      tick();
      rst = 1'b0;
      check_outs("rst_down", 0, 3'b000, 3'b000, 3'b000);
      for (int e = 0; e <= 9; e++) begin
         tick();
         check_outs("after_rst", e, 3'b000, 3'b000, 3'b000);
      end

`ifdef KEY_REPEAT_EN
      begin
         int n_rel;
         logic exp_p;
         kif.key_raw = 3'b001;
         for (int e = 0; e <= 42; e++) begin
            tick();
            exp_p = (e == 6) || (e >= 16 && ((e - 16) % 5) == 0);
            check_outs("repeat0", e, (e >= 6) ? 3'b001 : 3'b000, {2'b00, exp_p}, 3'b000);
         end
         kif.key_raw = 3'b000;
         n_rel = 0;
         for (int e = 0; e <= 10; e++) begin
            tick();
            if (kif.key_release[0]) n_rel++;
            check_outs("rpt_release0", e, (e >= 6) ? 3'b000 : 3'b001, 3'b000, (e == 6) ? 3'b001 : 3'b000);
         end
         check("rpt_release_count", 32'(n_rel), 32'd1);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
